// File: rtl/bp_pkg.sv
// Shared constants and helpers for the branch prediction table.
//   - Default values for the table parameters.
//   - Counter reset value: weakly not-taken, 2**(CTR_BITS-1)-1 (0 for 1-bit counters).
//   - stat_inc: 32-bit increment that sticks at all-ones instead of wrapping.
package bp_pkg;

  localparam int IDX_BITS_DEF = 6;
  localparam int CTR_BITS_DEF = 2;
  localparam int GHR_BITS_DEF = 6;
  localparam int GSHARE_DEF   = 1;

  // Reset value of a counter with the default width.
  localparam int CTR_RST_DEF  = (1 << (CTR_BITS_DEF - 1)) - 1;

  // Reset value for an arbitrary counter width.
  function automatic int ctr_rst_val(input int ctr_bits);
    return (1 << (ctr_bits - 1)) - 1;
  endfunction

  // Saturating increment used by the statistics counters.
  function automatic logic [31:0] stat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_sat_counter.sv
// Saturating up/down counter next-state logic (purely combinational).
// Ports:
//   value      : current counter value
//   taken      : resolved branch outcome (1 = count up, 0 = count down)
//   next_value : value after one step, clamped to [0, 2**CTR_BITS-1]
// With CTR_BITS=1 this degenerates to next_value = taken.
module branch_sat_counter #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] value,
  input  logic                taken,
  output logic [CTR_BITS-1:0] next_value
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

  always_comb begin
    next_value = value;
    if (taken) begin
      if (value != CTR_MAX) next_value = value + CTR_ONE;
    end else begin
      if (value != '0) next_value = value - CTR_ONE;
    end
  end

endmodule

// File: rtl/branch_predict_table.sv
// Branch direction predictor: table of saturating counters indexed by PC
// (bimodal) or PC XOR global history (gshare).
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   pred_valid, pred_pc   : IF-stage lookup request
//   pred_taken            : predicted direction (0 when no lookup)
//   pred_index            : table index used; carried down the pipe to EX
//   upd_valid, upd_index  : EX-stage retirement of a resolved branch
//   upd_taken             : actual outcome
//   upd_mispredict        : the earlier prediction was wrong
//   stat_branches         : saturating count of updates since reset
//   stat_mispredicts      : saturating count of mispredicted updates
// Lookup is combinational against the registered table, so a same-cycle
// update to the looked-up entry is only visible from the next cycle.
module branch_predict_table
  import bp_pkg::*;
#(
  parameter int IDX_BITS = IDX_BITS_DEF,
  parameter int CTR_BITS = CTR_BITS_DEF,
  parameter int GHR_BITS = GHR_BITS_DEF,
  parameter int GSHARE   = GSHARE_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pred_valid,
  input  logic [31:0]         pred_pc,
  output logic                pred_taken,
  output logic [IDX_BITS-1:0] pred_index,
  input  logic                upd_valid,
  input  logic [IDX_BITS-1:0] upd_index,
  input  logic                upd_taken,
  input  logic                upd_mispredict,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
);

  generate
    if (CTR_BITS < 1 || CTR_BITS > 4) begin : g_bad_ctr_bits
      $error("branch_predict_table: CTR_BITS must be in 1..4");
    end
    if (GHR_BITS < 1 || GHR_BITS > IDX_BITS) begin : g_bad_ghr_bits
      $error("branch_predict_table: GHR_BITS must be in 1..IDX_BITS");
    end
  endgenerate

  localparam int                  ENTRIES = 2 ** IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_rst_val(CTR_BITS));

  logic [CTR_BITS-1:0] ctr_reg [ENTRIES];
  logic [GHR_BITS-1:0] ghr_reg;
  logic [31:0]         branches_reg;
  logic [31:0]         mispredicts_reg;

  logic [IDX_BITS-1:0] pc_idx;
  logic [IDX_BITS-1:0] ghr_ext;
  logic [IDX_BITS-1:0] lookup_idx;
  logic [CTR_BITS-1:0] ctr_next;

  // PC bits outside the index field do not participate in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0]};

  // Word-aligned PC selects the entry; gshare folds in the history, which
  // is zero-extended so it only perturbs the low GHR_BITS index bits.
  assign pc_idx     = pred_pc[IDX_BITS+1:2];
  assign ghr_ext    = IDX_BITS'(ghr_reg);
  assign lookup_idx = (GSHARE != 0) ? (pc_idx ^ ghr_ext) : pc_idx;

  assign pred_index = lookup_idx;
  assign pred_taken = pred_valid & ctr_reg[lookup_idx][CTR_BITS-1];

  // Only one entry changes per cycle, so a single next-state instance
  // serves the whole table.
  branch_sat_counter #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_counter (
    .value      (ctr_reg[upd_index]),
    .taken      (upd_taken),
    .next_value (ctr_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_reg[i] <= CTR_RST;
      end
    end else if (upd_valid) begin
      ctr_reg[upd_index] <= ctr_next;
    end
  end

  // History advances only on retirement (non-speculative). Truncating the
  // concatenation drops the old MSB and works for GHR_BITS=1 too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr_reg <= '0;
    end else if (upd_valid) begin
      ghr_reg <= GHR_BITS'({ghr_reg, upd_taken});
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branches_reg    <= '0;
      mispredicts_reg <= '0;
    end else if (upd_valid) begin
      branches_reg <= stat_inc(branches_reg);
      if (upd_mispredict) mispredicts_reg <= stat_inc(mispredicts_reg);
    end
  end

  assign stat_branches    = branches_reg;
  assign stat_mispredicts = mispredicts_reg;

endmodule

// File: tb/tb_branch_predict_table.sv
// Self-checking bench for branch_predict_table with default parameters
// (64 entries, 2-bit counters, 6-bit history, gshare).
// A behavioural model (integer counters clamped to 0..3, history kept as an
// integer modulo 64) is compared against the outputs on every falling edge;
// directed steps add hand-computed literal expectations.
module tb_branch_predict_table;

  logic        clk;
  logic        reset_n;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [5:0]  pred_index;
  logic        upd_valid;
  logic [5:0]  upd_index;
  logic        upd_taken;
  logic        upd_mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  // Model state
  int     m_ctr [64];
  int     m_ghr;
  longint m_br;
  longint m_mp;

  branch_predict_table dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pred_valid       (pred_valid),
    .pred_pc          (pred_pc),
    .pred_taken       (pred_taken),
    .pred_index       (pred_index),
    .upd_valid        (upd_valid),
    .upd_index        (upd_index),
    .upd_taken        (upd_taken),
    .upd_mispredict   (upd_mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end else begin
      $display("ok   %s value=%0d at t=%0t", name, got, $time);
    end
  endtask

  // Behavioural model: counters in 0..3, taken predicted in upper half.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      m_ghr = 0;
      m_br  = 0;
      m_mp  = 0;
    end else if (upd_valid) begin
      if (upd_taken) m_ctr[upd_index] = (m_ctr[upd_index] < 3) ? m_ctr[upd_index] + 1 : 3;
      else           m_ctr[upd_index] = (m_ctr[upd_index] > 0) ? m_ctr[upd_index] - 1 : 0;
      m_ghr = (m_ghr * 2 + int'(upd_taken)) % 64;
      if (m_br < 64'hFFFF_FFFF) m_br++;
      if (upd_mispredict && m_mp < 64'hFFFF_FFFF) m_mp++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      int e_idx;
      e_idx = (int'(pred_pc[7:2]) ^ m_ghr) % 64;
      chk("cyc_pred_index", pred_index, e_idx);
      chk("cyc_pred_taken", pred_taken, (pred_valid && m_ctr[e_idx] >= 2) ? 1 : 0);
      chk("cyc_stat_branches", stat_branches, m_br);
      chk("cyc_stat_mispredicts", stat_mispredicts, m_mp);
    end
  end

  // One cycle of stimulus. lk_idx >= 0 chooses a PC that maps onto that
  // index under the current history; otherwise pc_raw is used.
  task automatic drive(input bit pv, input int lk_idx, input logic [31:0] pc_raw,
                       input bit uv, input int ui, input bit ut, input bit um);
    @(posedge clk);
    #1;
    pred_valid     = pv;
    pred_pc        = (lk_idx >= 0) ? 32'(((lk_idx ^ m_ghr) & 63) << 2) : pc_raw;
    upd_valid      = uv;
    upd_index      = 6'(ui);
    upd_taken      = ut;
    upd_mispredict = um;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_seq [4];
    pred_valid = 0; pred_pc = 0; upd_valid = 0; upd_index = 0;
    upd_taken = 0; upd_mispredict = 0; reset_n = 1;

    #2 reset_n = 0;
    started = 1;
    @(negedge clk); #1;
    pred_valid = 1; pred_pc = 32'h100;
    #1;
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_pred_index", pred_index, 0);
    chk("rst_stat_branches", stat_branches, 0);
    repeat (2) @(posedge clk);
    @(posedge clk); #1 reset_n = 1;

    // Lookup after reset
    drive(1, -1, 32'h100, 0, 0, 0, 0);
    chk("lk100_pred_index", pred_index, 0);
    chk("lk100_pred_taken", pred_taken, 0);

    // History 1,0,1 -> 000101 -> pc 0x100 maps to index 5
    drive(0, -1, 0, 1, 10, 1, 0);
    drive(0, -1, 0, 1, 10, 0, 1);
    drive(0, -1, 0, 1, 10, 1, 0);
    drive(1, -1, 32'h100, 0, 0, 0, 0);
    chk("ghr101_pred_index", pred_index, 5);
    chk("ghr101_pred_taken", pred_taken, 0);

    // Two taken updates at idx 5: 1 -> 2 -> 3
    drive(0, -1, 0, 1, 5, 1, 0);
    drive(0, -1, 0, 1, 5, 1, 0);
    drive(1, 5, 0, 0, 0, 0, 0);
    chk("idx5_ctr3_pred_index", pred_index, 5);
    chk("idx5_ctr3_pred_taken", pred_taken, 1);
    drive(0, -1, 0, 1, 5, 1, 0);
    drive(1, 5, 0, 0, 0, 0, 0);
    chk("idx5_sat3_pred_taken", pred_taken, 1);

    // Not-taken walk 3,2,1,0 with lookup each cycle, then hold at 0
    exp_seq = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      drive(1, 5, 0, 1, 5, 0, 0);
      chk($sformatf("nt_walk%0d_pred_taken", k), pred_taken, exp_seq[k]);
    end
    drive(1, 5, 0, 0, 0, 0, 0);
    chk("idx5_ctr0_pred_taken", pred_taken, 0);
    drive(0, -1, 0, 1, 5, 1, 0);
    drive(1, 5, 0, 0, 0, 0, 0);
    chk("idx5_sat0_then_up_pred_taken", pred_taken, 0);

    // Same-cycle lookup and update of idx 5 (counter 1, taken)
    drive(1, 5, 0, 1, 5, 1, 0);
    chk("bypass_same_cycle_pred_taken", pred_taken, 0);
    drive(1, 5, 0, 0, 0, 0, 0);
    chk("bypass_next_cycle_pred_taken", pred_taken, 1);

    // Fresh reset, then ten updates with four mispredicts
    drive(0, -1, 0, 0, 0, 0, 0);
    reset_n = 0;
    @(posedge clk); #1 reset_n = 1;
    for (int i = 0; i < 10; i++) begin
      drive(0, -1, 0, 1, (i * 3) % 64, i[0], (i % 3) == 0);
    end
    drive(0, -1, 0, 0, 0, 0, 1);
    drive(0, -1, 0, 0, 0, 0, 1);
    chk("stats_pre_branches", stat_branches, 10);
    chk("stats_pre_mispredicts", stat_mispredicts, 4);

    // Reset pulse mid-cycle with an update pending on the reset edges
    upd_valid = 1; upd_index = 0; upd_taken = 1; upd_mispredict = 1;
    #1 reset_n = 0;
    #1;
    chk("stats_async_branches", stat_branches, 0);
    chk("stats_async_mispredicts", stat_mispredicts, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1; upd_valid = 0; upd_mispredict = 0;
    for (int i = 0; i < 64; i++) begin
      drive(1, -1, 32'(i << 2), 0, 0, 0, 0);
      chk($sformatf("post_rst_idx%0d_pred_index", i), pred_index, i);
      chk($sformatf("post_rst_idx%0d_pred_taken", i), pred_taken, 0);
    end
    chk("post_rst_stat_branches", stat_branches, 0);

    // Counters really hold 1: one taken update lifts idx 9 to taken
    drive(0, -1, 0, 1, 9, 1, 0);
    drive(1, 9, 0, 0, 0, 0, 0);
    chk("post_rst_idx9_up_pred_taken", pred_taken, 1);

    @(negedge clk);
    started = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predict_table.md
BRANCH_PREDICT_TABLE -- requirements
Module: branch_predict_table

Interface
REQ-001 The block SHALL take parameter IDX_BITS, default 6: table index width; the table holds 2**IDX_BITS entries.
REQ-002 The block SHALL take parameter CTR_BITS, default 2: width of each saturating counter; legal range 1..4.
REQ-003 The block SHALL take parameter GHR_BITS, default 6: global history register width; legal range 1..IDX_BITS.
REQ-004 The block SHALL take parameter GSHARE, default 1: 1 = gshare indexing, 0 = bimodal (PC-only) indexing.
REQ-005 The block SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port pred_valid, input, 1 bit: a branch is being looked up this cycle (IF stage).
REQ-008 The block SHALL have port pred_pc, input, 32 bits: PC of the branch being looked up.
REQ-009 The block SHALL have port pred_taken, output, 1 bit: predicted direction.
REQ-010 The block SHALL have port pred_index, output, IDX_BITS: index used for this lookup; the pipeline carries it to EX unchanged.
REQ-011 The block SHALL have port upd_valid, input, 1 bit: a resolved branch is being retired into the table (EX stage).
REQ-012 The block SHALL have port upd_index, input, IDX_BITS: the pred_index originally returned for this branch.
REQ-013 The block SHALL have port upd_taken, input, 1 bit: actual branch outcome.
REQ-014 The block SHALL have port upd_mispredict, input, 1 bit: the prediction for this branch was wrong.
REQ-015 The block SHALL have port stat_branches, output, 32 bits: count of updates since reset.
REQ-016 The block SHALL have port stat_mispredicts, output, 32 bits: count of mispredicted updates since reset.

Function
REQ-017 Index generation SHALL be combinational: idx = pred_pc[IDX_BITS+1:2], XOR zero-extended GHR when GSHARE=1; idx SHALL drive pred_index.
REQ-018 pred_taken SHALL equal the MSB of counter[idx] when pred_valid=1, and 0 otherwise; lookup is combinational (zero latency).
REQ-019 On a clock edge with upd_valid=1 and upd_taken=1, counter[upd_index] SHALL increment, saturating at 2**CTR_BITS-1.
REQ-020 On a clock edge with upd_valid=1 and upd_taken=0, counter[upd_index] SHALL decrement, saturating at 0.
REQ-021 On a clock edge with upd_valid=1, GHR SHALL shift left by one, with upd_taken entering at bit 0 and the MSB discarded; GHR SHALL be non-speculative.
REQ-022 When upd_valid=0, counters and GHR SHALL hold their values; pred_valid SHALL never modify state.
REQ-023 When the same index is looked up and updated in one cycle, the lookup SHALL return the pre-update value; the new value SHALL be visible from the next cycle.
REQ-024 On each edge with upd_valid=1, stat_branches SHALL increment by 1; stat_mispredicts SHALL increment by 1 if upd_mispredict=1; both SHALL saturate at 32'hFFFF_FFFF.
REQ-025 upd_mispredict SHALL be ignored when upd_valid=0.
REQ-026 With CTR_BITS=1, each counter SHALL store the last outcome directly.
REQ-027 Illegal parameter combinations (GHR_BITS>IDX_BITS, CTR_BITS outside 1..4) SHALL fail at elaboration.

Reset
REQ-028 While reset_n=0, every counter SHALL be 2**(CTR_BITS-1)-1 (weakly not-taken; 0 when CTR_BITS=1).
REQ-029 While reset_n=0, GHR, stat_branches and stat_mispredicts SHALL be 0, so pred_taken=0 and pred_index=pred_pc[IDX_BITS+1:2].
REQ-030 Reset asserted mid-operation SHALL take effect immediately, and an update on the same edge SHALL be discarded.

Structure
REQ-031 Package bp_pkg SHALL hold the default parameter values, the counter-reset-value constant and the saturating-32-bit stat increment function.
REQ-032 Sub-module branch_sat_counter (parameter CTR_BITS; in: value, taken; out: next value) SHALL implement the saturating next-state logic and be instantiated once, on the update path.

Verification
REQ-033 Reset, then look up pc 0x100 -> pred_taken=0, pred_index=0x00 (GSHARE=1, GHR=0).
REQ-034 Two taken updates at index 5 -> counter 1->2->3; a lookup mapping to idx 5 predicts 1; a third taken update leaves the counter at 3.
REQ-035 From counter 3 at idx 5, three not-taken updates -> 2,1,0, with prediction going 1,1,0,0; a further not-taken update holds the counter at 0.
REQ-036 GSHARE=1, updates with taken=1,0,1 -> GHR=6'b000101; look up pc 0x100 -> pred_index=0x05.
REQ-037 Same-cycle lookup and update of idx 5 from counter 1 (taken) -> pred_taken=0 that cycle, 1 the next cycle.
REQ-038 Ten updates with four mispredicts, then reset_n pulsed mid-cycle -> stats read 10/4 before the pulse, 0/0 immediately after it, and all counters read back 1.
